sysid_regs: RTL and testbench

Parametrised system-identification and uptime peripheral on an Avalon-MM slave port. Returns a build-time system ID and timestamp, a free-running 64-bit uptime counter read atomically through a shadow register, a scratch register and a control register. Sits on the Qsys/Nios II data bus beside the LCD and other peripherals. Software uses it to confirm the loaded image and to measure elapsed time.

---
 rtl/sysid_pkg.sv | 12 +
 rtl/sysid_uptime.sv | 33 +++
 rtl/sysid_regs.sv | 86 ++++++++
 tb/tb_sysid_regs.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// Shared register map and CTRL bit positions for the sysid_regs peripheral.
package sysid_pkg;
    localparam int unsigned ADDR_ID      = 0;
    localparam int unsigned ADDR_TS      = 1;
    localparam int unsigned ADDR_UP_LO   = 2;
    localparam int unsigned ADDR_UP_HI   = 3;
    localparam int unsigned ADDR_SCRATCH = 4;
    localparam int unsigned ADDR_CTRL    = 5;

    localparam int unsigned CTRL_FREEZE  = 0;
    localparam int unsigned CTRL_CLEAR   = 1;
endpackage

// File: rtl/sysid_uptime.sv
// Prescaled free-running 64-bit uptime counter with freeze and clear.
module sysid_uptime #(
    parameter int TICK_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        freeze,
    input  logic        clear,
    output logic [63:0] uptime
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescale;
    logic [63:0]   count;

    // Clear outranks both freeze and the tick so software gets an exact zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prescale <= '0;
            count    <= '0;
        end else if (!freeze) begin
            if (prescale == PRE_LAST) begin
                prescale <= '0;
                count    <= count + 64'd1;
            end else begin
                prescale <= prescale + PW'(1);
            end
        end
    end

    assign uptime = count;
endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system ID / uptime peripheral: ID, timestamp, atomic uptime, scratch, ctrl.
module sysid_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
    parameter int          ADDR_W        = 3,
    parameter int          TICK_DIV      = 1,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int          HB_BIT        = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid,
    output logic              heartbeat
);
    localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(ADDR_ID);
    localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(ADDR_TS);
    localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(ADDR_UP_LO);
    localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(ADDR_UP_HI);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(ADDR_SCRATCH);
    localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(ADDR_CTRL);

    logic [63:0] uptime;
    logic [31:0] hi_shadow;
    logic [31:0] scratch;
    logic        freeze;
    logic        clear;
    logic        wr_ctrl;
    logic [31:0] rdata_mux;

    assign wr_ctrl = write && (address == A_CTRL) && byteenable[0];
    assign clear   = wr_ctrl && writedata[CTRL_CLEAR];

    sysid_uptime #(
        .TICK_DIV(TICK_DIV)
    ) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .freeze (freeze),
        .clear  (clear),
        .uptime (uptime)
    );

    always_comb begin
        rdata_mux = '0;
        case (address)
            A_ID:      rdata_mux = SYSTEM_ID;
            A_TS:      rdata_mux = TIMESTAMP;
            A_UP_LO:   rdata_mux = uptime[31:0];
            A_UP_HI:   rdata_mux = hi_shadow;
            A_SCRATCH: rdata_mux = scratch;
            A_CTRL:    rdata_mux[CTRL_FREEZE] = freeze;
            default:   rdata_mux = '0;
        endcase
    end

    // Read mux samples pre-edge state, so a colliding write is seen by the next read only.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch       <= SCRATCH_RESET;
            freeze        <= 1'b0;
            hi_shadow     <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
            heartbeat     <= 1'b0;
        end else begin
            if (write && address == A_SCRATCH) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
            if (wr_ctrl) freeze <= writedata[CTRL_FREEZE];
            if (read && address == A_UP_LO) hi_shadow <= uptime[63:32];
            readdatavalid <= read;
            readdata      <= read ? rdata_mux : '0;
            heartbeat     <= uptime[HB_BIT];
        end
    end
endmodule

// File: tb/tb_sysid_regs.sv
// Directed self-checking bench for sysid_regs (TICK_DIV=4, HB_BIT=2).
module tb_sysid_regs;
    localparam logic [31:0] SYS_ID  = 32'h5538_D49B;
    localparam logic [31:0] TS      = 32'h4C8A_1234;
    localparam logic [31:0] SCR_RST = 32'hA5A5_0001;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        heartbeat;

    int tests = 0;
    int fails = 0;

    sysid_regs #(
        .SYSTEM_ID     (SYS_ID),
        .TIMESTAMP     (TS),
        .ADDR_W        (3),
        .TICK_DIV      (4),
        .SCRATCH_RESET (SCR_RST),
        .HB_BIT        (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .heartbeat     (heartbeat)
    );

    always #5 clock = ~clock;

    // Drive at the current point (a falling edge), strobe is sampled on the next rising edge.
    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        address = a; read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = readdata; v = readdatavalid;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic v;
        tests++; if (readdatavalid !== 1'b0) begin fails++; $display("FAIL rst_rdv: got %b want 0", readdatavalid); end
        tests++; if (readdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", readdata); end
        tests++; if (heartbeat !== 1'b0) begin fails++; $display("FAIL rst_hb: got %b want 0", heartbeat); end
        do_read(3'd3, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_hi_shadow: got %h want 0", d); end
        do_read(3'd4, d, v);
        tests++; if (d !== SCR_RST) begin fails++; $display("FAIL rst_scratch: got %h want %h", d, SCR_RST); end
        do_read(3'd5, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rst_ctrl: got %h want 0", d); end
    endtask

    task automatic test_id;
        logic [31:0] d; logic v;
        do_read(3'd0, d, v);
        tests++; if (v !== 1'b1 || d !== SYS_ID) begin fails++; $display("FAIL id: got %h v=%b want %h", d, v, SYS_ID); end
        do_read(3'd1, d, v);
        tests++; if (v !== 1'b1 || d !== TS) begin fails++; $display("FAIL ts: got %h v=%b want %h", d, v, TS); end
        do_read(3'd7, d, v);
        tests++; if (v !== 1'b1 || d !== 32'h0) begin fails++; $display("FAIL addr7: got %h v=%b want 0", d, v); end
        @(negedge clock);
        tests++; if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin fails++; $display("FAIL idle_rd: got %h v=%b want 0", readdata, readdatavalid); end
    endtask

    task automatic test_scratch;
        logic [31:0] d; logic v;
        do_write(3'd4, 32'hDEAD_BEEF, 4'hF);
        do_write(3'd4, 32'h0000_0011, 4'h1);
        do_read(3'd4, d, v);
        tests++; if (d !== 32'hDEAD_BE11) begin fails++; $display("FAIL scratch_be: got %h want deadbe11", d); end
        do_write(3'd6, 32'hFFFF_FFFF, 4'hF);
        do_read(3'd6, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL addr6: got %h want 0", d); end
        do_read(3'd4, d, v);
        tests++; if (d !== 32'hDEAD_BE11) begin fails++; $display("FAIL scratch_keep: got %h want deadbe11", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d; logic v;
        address = 3'd0; read = 1'b1;
        @(negedge clock);
        address = 3'd1;
        tests++; if (readdatavalid !== 1'b1 || readdata !== SYS_ID) begin fails++; $display("FAIL b2b_0: got %h v=%b", readdata, readdatavalid); end
        @(negedge clock);
        read = 1'b0;
        tests++; if (readdatavalid !== 1'b1 || readdata !== TS) begin fails++; $display("FAIL b2b_1: got %h v=%b", readdata, readdatavalid); end
    endtask

    // Reset released at a falling edge; uptime = floor(rising edges / 4).
    task automatic test_uptime;
        logic [31:0] d, a; logic v;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (16) @(negedge clock);
        tests++; if (heartbeat !== 1'b0) begin fails++; $display("FAIL hb_lag0: got %b want 0", heartbeat); end
        @(negedge clock);
        tests++; if (heartbeat !== 1'b1) begin fails++; $display("FAIL hb_lag1: got %b want 1", heartbeat); end
        repeat (23) @(negedge clock);
        do_read(3'd2, d, v);
        tests++; if (v !== 1'b1 || d !== 32'd10) begin fails++; $display("FAIL uptime40: got %0d want 10", d); end
        do_write(3'd5, 32'h1, 4'hF);
        do_read(3'd2, a, v);
        repeat (20) @(negedge clock);
        do_read(3'd2, d, v);
        tests++; if (a !== 32'd10 || d !== 32'd10) begin fails++; $display("FAIL freeze: got %0d/%0d want 10/10", a, d); end
    endtask

    task automatic test_shadow;
        logic [31:0] d; logic v;
        do_write(3'd5, 32'h3, 4'hF);
        force dut.u_uptime.count = 64'h0000_0001_FFFF_FFFF;
        #1 release dut.u_uptime.count;
        do_read(3'd2, d, v);
        tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL preload_lo: got %h want ffffffff", d); end
        do_write(3'd5, 32'h0, 4'hF);
        repeat (4) @(negedge clock);
        do_write(3'd5, 32'h1, 4'hF);
        do_read(3'd3, d, v);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL shadow_hi: got %h want 1", d); end
        do_read(3'd2, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL carry_lo: got %h want 0", d); end
        do_read(3'd3, d, v);
        tests++; if (d !== 32'h2) begin fails++; $display("FAIL carry_hi: got %h want 2", d); end
    endtask

    task automatic test_wrap;
        logic [31:0] d; logic v;
        do_write(3'd5, 32'h3, 4'hF);
        force dut.u_uptime.count = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.u_uptime.count;
        do_read(3'd2, d, v);
        do_read(3'd3, d, v);
        tests++; if (d !== 32'hFFFF_FFFF) begin fails++; $display("FAIL ones_hi: got %h want ffffffff", d); end
        do_write(3'd5, 32'h0, 4'hF);
        repeat (4) @(negedge clock);
        do_write(3'd5, 32'h1, 4'hF);
        do_read(3'd2, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL wrap_lo: got %h want 0", d); end
        do_read(3'd3, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL wrap_hi: got %h want 0", d); end
    endtask

    task automatic test_ctrl_clear;
        logic [31:0] d; logic v;
        do_write(3'd5, 32'h0, 4'hF);
        repeat (12) @(negedge clock);
        do_read(3'd2, d, v);
        tests++; if (d === 32'h0) begin fails++; $display("FAIL run_nonzero: got %h want nonzero", d); end
        do_write(3'd5, 32'h3, 4'hF);
        do_read(3'd2, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL clear_lo: got %h want 0", d); end
        do_read(3'd5, d, v);
        tests++; if (d !== 32'h1) begin fails++; $display("FAIL ctrl_rd: got %h want 1", d); end
        do_write(3'd4, 32'h1234_5678, 4'hF);
        address = 3'd4; writedata = 32'hCAFE_F00D; byteenable = 4'hF; read = 1'b1; write = 1'b1;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        tests++; if (readdatavalid !== 1'b1 || readdata !== 32'h1234_5678) begin fails++; $display("FAIL rw_old: got %h v=%b want 12345678", readdata, readdatavalid); end
        do_read(3'd4, d, v);
        tests++; if (d !== 32'hCAFE_F00D) begin fails++; $display("FAIL rw_new: got %h want cafef00d", d); end
    endtask

    task automatic test_reset_after_read;
        logic [31:0] d; logic v;
        address = 3'd0; read = 1'b1;
        @(negedge clock);
        read = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests++; if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin fails++; $display("FAIL rar_drop: got %h v=%b want 0", readdata, readdatavalid); end
        do_read(3'd3, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rar_hi: got %h want 0", d); end
        do_read(3'd2, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rar_lo: got %h want 0", d); end
        do_read(3'd4, d, v);
        tests++; if (d !== SCR_RST) begin fails++; $display("FAIL rar_scratch: got %h want %h", d, SCR_RST); end
        do_read(3'd5, d, v);
        tests++; if (d !== 32'h0) begin fails++; $display("FAIL rar_ctrl: got %h want 0", d); end
    endtask

    initial begin
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset;
        test_id;
        test_scratch;
        test_back_to_back;
        test_uptime;
        test_shadow;
        test_wrap;
        test_ctrl_clear;
        test_reset_after_read;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
